id_stage_fwd: RTL and testbench
===============================

Name: id_stage_fwd

Overview:
- Parametrised decode stage for the 5-stage MIPS-style pipeline, sitting between IF and EX.
- Decodes a logic/shift/LUI/LW subset and forwards operands from EX and MEM.
- Detects load-use hazards and inserts a bubble when one occurs.
- Drives EX through a registered valid/ready output stage with flush support.

Parameters:
DW, 32, datapath width; must be >= 32; immediates extend to DW
AW, 5, register address width
NREG, 32, architectural register count; register 0 is hard-wired zero

Ports:
clk  in  1  clock
reset_n  in  1  reset, asynchronous, active-low
if_valid_i  in  1  IF presents an instruction
if_ready_o  out  1  ID accepts the instruction this cycle
pc_i  in  32  instruction PC
inst_i  in  32  instruction word
flush_i  in  1  squash the held instruction and the incoming one
rf_raddr1_o  out  AW  regfile read address 1 (combinational, rs)
rf_raddr2_o  out  AW  regfile read address 2 (combinational, rt)
rf_rdata1_i  in  DW  regfile read data 1
rf_rdata2_i  in  DW  regfile read data 2
ex_we/ex_waddr/ex_wdata  in  1/AW/DW  EX-stage write-back candidate
ex_is_load  in  1  EX instruction is a load; its data is not yet valid
mem_we/mem_waddr/mem_wdata  in  1/AW/DW  MEM-stage write-back candidate
ex_ready_i  in  1  EX accepts id_valid_o
id_valid_o  out  1  output bundle valid
pc_o  out  32  registered PC
aluop_o  out  8  ALU operation
alusel_o  out  3  ALU result select
reg1_data_o  out  DW  operand 1
reg2_data_o  out  DW  operand 2
wreg_o  out  1  write-back enable
waddr_o  out  AW  write-back address

Behaviour:
- Reset: all outputs 0, including id_valid_o. if_ready_o=1 once out of reset.
- Output register: loads on accept = if_valid_i & if_ready_o & !flush_i.
  - if_ready_o = (!id_valid_o | ex_ready_i) & !hazard.
  - Held stable while id_valid_o & !ex_ready_i.
  - Latency IF->ID output: 1 cycle.
  - Throughput: 1 instruction/cycle when there is no hazard.
- id_valid_o next state:
  - 0 if flush_i.
  - else 1 on accept.
  - else 0 if ex_ready_i.
  - else unchanged.
- Decode (package values):
  - SPECIAL funct AND/OR/XOR/NOR: alusel LOGIC 3'b001; rs, rt read; waddr=rd.
  - SPECIAL funct SLL/SRL/SRA: alusel SHIFT 3'b010; op1=zero-ext shamt; op2=rt; waddr=rd.
  - ANDI/ORI/XORI: LOGIC; op1=rs; op2=zero-ext imm16; waddr=rt.
  - LUI: LOGIC, aluop OR; op1=0; op2={imm16,16'b0}; waddr=rt.
  - LW: alusel LOADSTORE 3'b111; op1=rs; op2=sign-ext imm16; waddr=rt.
  - Anything else: NOP (aluop 0, alusel 0, wreg 0), still valid.
- Forwarding, per operand, applied before the output register:
  - Priority: ex match, then mem match, then regfile.
  - Match condition: read enabled & we & waddr==raddr & raddr!=0.
  - Address 0 always reads 0.
  - A write with waddr 0 never writes (wreg forced 0 when waddr==0).
- Load-use hazard:
  - hazard = if_valid_i & ex_we & ex_is_load & ex_waddr!=0 & ex_waddr matches an enabled read address.
  - if_ready_o=0; a bubble (id_valid_o=0) enters EX once the held bundle drains.
  - Resolves the cycle the load leaves EX.
- Flush:
  - Wins over accept and hazard.
  - Output valid clears next edge; no partial decode leaks.
- Reset mid-operation: outputs return to reset values immediately (asynchronous).

Optional Feature:
ID_ILLEGAL_TRAP_EN
- Defined:
  - Adds output illegal_o (1 bit, registered alongside the bundle).
  - Unknown opcode/funct sets illegal_o=1 and wreg_o=0.
  - Illegal instructions are accepted normally.
- Undefined:
  - No port.
  - Unknown encodings silently decode as NOP.

Decomposition:
- Package id_pkg holds:
  - opcode and funct constants;
  - aluop codes: AND 8'h24, OR 8'h25, XOR 8'h26, NOR 8'h27, SLL 8'h7C, SRL 8'h02, SRA 8'h03, LW 8'hE3, NOP 8'h00;
  - alusel codes;
  - the decode-bundle typedef.
- Sub-module id_fwd_mux:
  - Parametrised by DW and AW.
  - One instance per operand.
  - Contains the ex/mem/regfile priority and the zero-register rule.

Test Plan:
- ORI $1,$0,0x1100, no forwarding -> next cycle id_valid_o=1, aluop 8'h25, alusel 3'b001, reg2_data=32'h00001100, waddr=1, wreg=1.
- ex_we=1, ex_waddr=3, ex_wdata=32'hA5A5_0000 plus mem_we=1, mem_waddr=3, mem_wdata=32'h1, then OR $4,$3,$0 -> reg1_data=32'hA5A5_0000 (EX wins).
- ex_is_load=1, ex_waddr=5, then ADD-free AND $6,$5,$2 -> if_ready_o=0 for 1 cycle, bubble id_valid_o=0; after the load clears, accepted with mem-forwarded data.
- ex_ready_i=0 for 3 cycles while holding LUI $2,0xDEAD -> outputs stable, reg2_data=32'hDEAD_0000; if_ready_o=0 throughout.
- flush_i=1 together with if_valid_i=1 -> id_valid_o=0 next cycle; instruction discarded.
- Opcode 6'b111111 -> with ID_ILLEGAL_TRAP_EN, illegal_o=1 and wreg_o=0; without it, aluop 8'h00 and wreg_o=0.

Source files
------------

// File: rtl/id_pkg.sv
// Decode constants, ALU codes and the decode bundle for the ID stage.
package id_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;

  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_SRA = 6'h03;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_XOR = 6'h26;
  localparam logic [5:0] F_NOR = 6'h27;

  localparam logic [7:0] ALU_NOP = 8'h00;
  localparam logic [7:0] ALU_AND = 8'h24;
  localparam logic [7:0] ALU_OR  = 8'h25;
  localparam logic [7:0] ALU_XOR = 8'h26;
  localparam logic [7:0] ALU_NOR = 8'h27;
  localparam logic [7:0] ALU_SLL = 8'h7C;
  localparam logic [7:0] ALU_SRL = 8'h02;
  localparam logic [7:0] ALU_SRA = 8'h03;
  localparam logic [7:0] ALU_LW  = 8'hE3;

  typedef enum logic [2:0] {
    SEL_NOP       = 3'b000,
    SEL_LOGIC     = 3'b001,
    SEL_SHIFT     = 3'b010,
    SEL_LOADSTORE = 3'b111
  } alusel_e;

  // imm1/imm2 are the operands used when the matching read port is disabled
  typedef struct packed {
    logic [7:0]  aluop;
    alusel_e     alusel;
    logic        re1;
    logic        re2;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        wreg;
    logic [4:0]  waddr;
    logic [31:0] imm1;
    logic [31:0] imm2;
    logic        imm_sext;
    logic        illegal;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] inst);
    dec_t d;
    d        = '0;
    d.raddr1 = inst[25:21];
    d.raddr2 = inst[20:16];
    case (inst[31:26])
      OP_SPECIAL: begin
        d.waddr = inst[15:11];
        d.wreg  = 1'b1;
        d.re2   = 1'b1;
        case (inst[5:0])
          F_AND: begin d.aluop = ALU_AND; d.alusel = SEL_LOGIC; d.re1 = 1'b1; end
          F_OR:  begin d.aluop = ALU_OR;  d.alusel = SEL_LOGIC; d.re1 = 1'b1; end
          F_XOR: begin d.aluop = ALU_XOR; d.alusel = SEL_LOGIC; d.re1 = 1'b1; end
          F_NOR: begin d.aluop = ALU_NOR; d.alusel = SEL_LOGIC; d.re1 = 1'b1; end
          F_SLL: begin d.aluop = ALU_SLL; d.alusel = SEL_SHIFT; d.imm1 = {27'b0, inst[10:6]}; end
          F_SRL: begin d.aluop = ALU_SRL; d.alusel = SEL_SHIFT; d.imm1 = {27'b0, inst[10:6]}; end
          F_SRA: begin d.aluop = ALU_SRA; d.alusel = SEL_SHIFT; d.imm1 = {27'b0, inst[10:6]}; end
          default: begin
            d.wreg = 1'b0; d.re2 = 1'b0; d.waddr = '0; d.illegal = 1'b1;
          end
        endcase
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        d.aluop  = (inst[31:26] == OP_ANDI) ? ALU_AND :
                   (inst[31:26] == OP_ORI)  ? ALU_OR  : ALU_XOR;
        d.alusel = SEL_LOGIC;
        d.re1    = 1'b1;
        d.imm2   = {16'b0, inst[15:0]};
        d.wreg   = 1'b1;
        d.waddr  = inst[20:16];
      end
      OP_LUI: begin
        d.aluop  = ALU_OR;
        d.alusel = SEL_LOGIC;
        d.imm2   = {inst[15:0], 16'b0};
        d.wreg   = 1'b1;
        d.waddr  = inst[20:16];
      end
      OP_LW: begin
        d.aluop    = ALU_LW;
        d.alusel   = SEL_LOADSTORE;
        d.re1      = 1'b1;
        d.imm2     = {{16{inst[15]}}, inst[15:0]};
        d.imm_sext = 1'b1;
        d.wreg     = 1'b1;
        d.waddr    = inst[20:16];
      end
      default: d.illegal = 1'b1;
    endcase
    if (d.waddr == '0) d.wreg = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// Per-operand bypass select: EX over MEM over regfile; register 0 reads zero.
module id_fwd_mux #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          re,
  input  logic [AW-1:0] raddr,
  input  logic [DW-1:0] rf_rdata,
  input  logic          ex_we,
  input  logic [AW-1:0] ex_waddr,
  input  logic [DW-1:0] ex_wdata,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_waddr,
  input  logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] rdata
);

  always_comb begin
    rdata = '0;
    if (re && raddr != '0) begin
      if (ex_we && ex_waddr == raddr)        rdata = ex_wdata;
      else if (mem_we && mem_waddr == raddr) rdata = mem_wdata;
      else                                   rdata = rf_rdata;
    end
  end

endmodule

// File: rtl/id_stage_fwd.sv
// Decode stage with EX/MEM forwarding, load-use stall and registered EX handshake.
// Build option: ID_ILLEGAL_TRAP_EN adds illegal_o for unknown encodings.
module id_stage_fwd
  import id_pkg::*;
#(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int NREG = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          if_valid_i,
  output logic          if_ready_o,
  input  logic [31:0]   pc_i,
  input  logic [31:0]   inst_i,
  input  logic          flush_i,
  output logic [AW-1:0] rf_raddr1_o,
  output logic [AW-1:0] rf_raddr2_o,
  input  logic [DW-1:0] rf_rdata1_i,
  input  logic [DW-1:0] rf_rdata2_i,
  input  logic          ex_we,
  input  logic [AW-1:0] ex_waddr,
  input  logic [DW-1:0] ex_wdata,
  input  logic          ex_is_load,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_waddr,
  input  logic [DW-1:0] mem_wdata,
  input  logic          ex_ready_i,
  output logic          id_valid_o,
  output logic [31:0]   pc_o,
  output logic [7:0]    aluop_o,
  output logic [2:0]    alusel_o,
  output logic [DW-1:0] reg1_data_o,
  output logic [DW-1:0] reg2_data_o,
  output logic          wreg_o,
  output logic [AW-1:0] waddr_o
`ifdef ID_ILLEGAL_TRAP_EN
  ,
  output logic          illegal_o
`endif
);

  localparam logic [AW:0] NREG_W = NREG[AW:0];

  dec_t                 dec;
  logic [1:0]           re_v;
  logic [1:0][AW-1:0]   ra_v;
  logic [1:0][DW-1:0]   rf_v, fwd_v;
  logic [DW-1:0]        op1, op2, imm1_x, imm2_x;
  logic                 hazard, accept;

  assign dec         = decode(inst_i);
  assign rf_raddr1_o = AW'(dec.raddr1);
  assign rf_raddr2_o = AW'(dec.raddr2);
  assign ra_v[0]     = rf_raddr1_o;
  assign ra_v[1]     = rf_raddr2_o;
  assign rf_v[0]     = rf_rdata1_i;
  assign rf_v[1]     = rf_rdata2_i;
  // addresses beyond the implemented register file read as zero
  assign re_v[0]     = dec.re1 & ({1'b0, ra_v[0]} < NREG_W);
  assign re_v[1]     = dec.re2 & ({1'b0, ra_v[1]} < NREG_W);

  for (genvar i = 0; i < 2; i++) begin : g_opnd
    id_fwd_mux #(.DW(DW), .AW(AW)) u_fwd (
      .re       (re_v[i]),
      .raddr    (ra_v[i]),
      .rf_rdata (rf_v[i]),
      .ex_we    (ex_we),
      .ex_waddr (ex_waddr),
      .ex_wdata (ex_wdata),
      .mem_we   (mem_we),
      .mem_waddr(mem_waddr),
      .mem_wdata(mem_wdata),
      .rdata    (fwd_v[i])
    );
  end

  assign imm1_x = DW'(dec.imm1);
  assign imm2_x = dec.imm_sext ? DW'($signed(dec.imm2)) : DW'(dec.imm2);
  assign op1    = dec.re1 ? fwd_v[0] : imm1_x;
  assign op2    = dec.re2 ? fwd_v[1] : imm2_x;

  // a load in EX has no data yet, so a dependent read must wait a cycle
  assign hazard = if_valid_i & ex_we & ex_is_load & (ex_waddr != '0) &
                  ((dec.re1 & (ex_waddr == rf_raddr1_o)) |
                   (dec.re2 & (ex_waddr == rf_raddr2_o)));

  assign if_ready_o = (~id_valid_o | ex_ready_i) & ~hazard;
  assign accept     = if_valid_i & if_ready_o & ~flush_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      id_valid_o  <= 1'b0;
      pc_o        <= '0;
      aluop_o     <= '0;
      alusel_o    <= '0;
      reg1_data_o <= '0;
      reg2_data_o <= '0;
      wreg_o      <= 1'b0;
      waddr_o     <= '0;
    end else begin
      if (flush_i)         id_valid_o <= 1'b0;
      else if (accept)     id_valid_o <= 1'b1;
      else if (ex_ready_i) id_valid_o <= 1'b0;
      if (accept) begin
        pc_o        <= pc_i;
        aluop_o     <= dec.aluop;
        alusel_o    <= dec.alusel;
        reg1_data_o <= op1;
        reg2_data_o <= op2;
        wreg_o      <= dec.wreg;
        waddr_o     <= AW'(dec.waddr);
      end
    end
  end

`ifdef ID_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    illegal_o <= 1'b0;
    else if (accept) illegal_o <= dec.illegal;
  end
`else
  logic unused_illegal;
  assign unused_illegal = dec.illegal;
`endif

endmodule

// File: tb/tb_id_stage_fwd.sv
// Scoreboard bench for id_stage_fwd: directed vectors, monitor pops on EX handshake.
module tb_id_stage_fwd;

  localparam int DW = 32;
  localparam int AW = 5;
`ifdef ID_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0]   pc;
    logic [7:0]    aluop;
    logic [2:0]    alusel;
    logic [DW-1:0] r1;
    logic [DW-1:0] r2;
    logic          wreg;
    logic [AW-1:0] waddr;
    logic          ill;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          if_valid_i, if_ready_o, flush_i;
  logic [31:0]   pc_i, inst_i;
  logic [AW-1:0] rf_raddr1_o, rf_raddr2_o;
  logic [DW-1:0] rf_rdata1_i, rf_rdata2_i;
  logic          ex_we, ex_is_load, mem_we, ex_ready_i;
  logic [AW-1:0] ex_waddr, mem_waddr;
  logic [DW-1:0] ex_wdata, mem_wdata;
  logic          id_valid_o, wreg_o;
  logic [31:0]   pc_o;
  logic [7:0]    aluop_o;
  logic [2:0]    alusel_o;
  logic [DW-1:0] reg1_data_o, reg2_data_o;
  logic [AW-1:0] waddr_o;
`ifdef ID_ILLEGAL_TRAP_EN
  logic          illegal_o;
`endif

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  // register r reads as 0x1000_0000 + r
  assign rf_rdata1_i = {27'h0800000, rf_raddr1_o};
  assign rf_rdata2_i = {27'h0800000, rf_raddr2_o};

  id_stage_fwd #(.DW(DW), .AW(AW), .NREG(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_valid_i(if_valid_i), .if_ready_o(if_ready_o),
    .pc_i(pc_i), .inst_i(inst_i), .flush_i(flush_i),
    .rf_raddr1_o(rf_raddr1_o), .rf_raddr2_o(rf_raddr2_o),
    .rf_rdata1_i(rf_rdata1_i), .rf_rdata2_i(rf_rdata2_i),
    .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .ex_ready_i(ex_ready_i), .id_valid_o(id_valid_o), .pc_o(pc_o),
    .aluop_o(aluop_o), .alusel_o(alusel_o),
    .reg1_data_o(reg1_data_o), .reg2_data_o(reg2_data_o),
    .wreg_o(wreg_o), .waddr_o(waddr_o)
`ifdef ID_ILLEGAL_TRAP_EN
    , .illegal_o(illegal_o)
`endif
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [7:0] aluop, input logic [2:0] alusel,
                      input logic [DW-1:0] r1, input logic [DW-1:0] r2, input logic wreg,
                      input logic [AW-1:0] waddr, input logic ill);
    exp_t e;
    e = '{pc, aluop, alusel, r1, r2, wreg, waddr, ill};
    q.push_back(e);
  endtask

  task automatic send(input logic [31:0] inst, input logic [31:0] pc);
    if_valid_i = 1'b1; inst_i = inst; pc_i = pc;
    step();
  endtask

  // monitor: every EX handshake must match the oldest expected bundle
  always @(negedge clk) begin
    if (reset_n && id_valid_o && ex_ready_i) begin
      exp_t a, e;
      a = '{pc_o, aluop_o, alusel_o, reg1_data_o, reg2_data_o, wreg_o, waddr_o, 1'b0};
`ifdef ID_ILLEGAL_TRAP_EN
      a.ill = illegal_o;
`endif
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out: got %0h want none", a);
      end else begin
        e = q.pop_front();
        if (a !== e) begin
          bad++;
          $display("FAIL bundle pc=%0h: got %0h want %0h", e.pc, a, e);
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0; if_valid_i = 0; flush_i = 0; pc_i = 0; inst_i = 0;
    ex_we = 0; ex_waddr = 0; ex_wdata = 0; ex_is_load = 0;
    mem_we = 0; mem_waddr = 0; mem_wdata = 0; ex_ready_i = 1'b1;
    #2;
    chk("reset_out", {id_valid_o, pc_o, aluop_o, alusel_o, wreg_o, waddr_o}, '0);
    chk("reset_data", {reg1_data_o, reg2_data_o}, '0);
    step();
    reset_n = 1'b1;
    #1 chk("ready_after_reset", if_ready_o, 1);
    step();

    // ORI $1,$0,0x1100
    push(32'h100, 8'h25, 3'b001, 32'h0, 32'h0000_1100, 1, 5'd1, 0);
    send(32'h3401_1100, 32'h100);

    // OR $4,$3,$0 with EX and MEM both writing $3: EX wins
    ex_we = 1; ex_waddr = 5'd3; ex_wdata = 32'hA5A5_0000;
    mem_we = 1; mem_waddr = 5'd3; mem_wdata = 32'h1;
    push(32'h104, 8'h25, 3'b001, 32'hA5A5_0000, 32'h0, 1, 5'd4, 0);
    send(32'h0060_2025, 32'h104);

    // XOR $7,$8,$9: MEM forwards rt, EX targets an unrelated register
    ex_waddr = 5'd2; mem_waddr = 5'd9; mem_wdata = 32'h55;
    push(32'h108, 8'h26, 3'b001, 32'h1000_0008, 32'h55, 1, 5'd7, 0);
    send(32'h0109_3826, 32'h108);

    // load-use: AND $6,$5,$2 behind LW $5 in EX
    ex_we = 1; ex_is_load = 1; ex_waddr = 5'd5; ex_wdata = 32'hDEAD_BEEF; mem_we = 0;
    if_valid_i = 1; inst_i = 32'h00A2_3024; pc_i = 32'h10C;
    #1 chk("haz_ready", if_ready_o, 0);
    step();
    chk("bubble", id_valid_o, 0);
    ex_we = 0; ex_is_load = 0; mem_we = 1; mem_waddr = 5'd5; mem_wdata = 32'hCAFE_0005;
    #1 chk("haz_clear", if_ready_o, 1);
    push(32'h10C, 8'h24, 3'b001, 32'hCAFE_0005, 32'h1000_0002, 1, 5'd6, 0);
    step();
    mem_we = 0;

    // LUI $2,0xDEAD held for 3 cycles while ANDI waits behind it
    push(32'h110, 8'h25, 3'b001, 32'h0, 32'hDEAD_0000, 1, 5'd2, 0);
    send(32'h3C02_DEAD, 32'h110);
    ex_ready_i = 0; inst_i = 32'h3023_00FF; pc_i = 32'h114;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_ready", if_ready_o, 0);
      chk("stall_hold", {id_valid_o, pc_o, aluop_o, reg2_data_o, waddr_o},
          {1'b1, 32'h110, 8'h25, 32'hDEAD_0000, 5'd2});
      step();
    end
    ex_ready_i = 1;
    push(32'h114, 8'h24, 3'b001, 32'h1000_0001, 32'h0000_00FF, 1, 5'd3, 0);
    step();

    // SRA $10,$11,4 / LW $12,-4($13) / ORI $0,$1,5 / unknown opcode
    push(32'h118, 8'h03, 3'b010, 32'h4, 32'h1000_000B, 1, 5'd10, 0);
    send(32'h000B_5103, 32'h118);
    push(32'h11C, 8'hE3, 3'b111, 32'h1000_000D, 32'hFFFF_FFFC, 1, 5'd12, 0);
    send(32'h8DAC_FFFC, 32'h11C);
    push(32'h120, 8'h25, 3'b001, 32'h1000_0001, 32'h5, 0, 5'd0, 0);
    send(32'h3420_0005, 32'h120);
    push(32'h124, 8'h00, 3'b000, 32'h0, 32'h0, 0, 5'd0, TRAP);
    send(32'hFC00_0000, 32'h124);
    if_valid_i = 0;

    for (int i = 0; i < 20 && q.size() != 0; i++) step();
    chk("drain_left", q.size(), 0);

    // flush kills a held bundle, then an incoming one
    ex_ready_i = 0;
    send(32'h3401_1100, 32'h200);
    flush_i = 1; inst_i = 32'h3C02_DEAD; pc_i = 32'h204;
    step();
    chk("flush_held", id_valid_o, 0);
    ex_ready_i = 1;
    step();
    chk("flush_in", id_valid_o, 0);
    flush_i = 0;

    // asynchronous reset mid-operation
    ex_ready_i = 0;
    send(32'h3C02_DEAD, 32'h208);
    if_valid_i = 0;
    chk("pre_reset_valid", id_valid_o, 1);
    reset_n = 0;
    #1;
    chk("async_reset", {id_valid_o, pc_o, aluop_o, reg2_data_o, wreg_o}, '0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
